// File: rtl/dmem_burst_master_pkg.sv
// Shared definitions for the data-memory burst master: block geometry and FSM state encoding.
package dmem_burst_master_pkg;

  localparam int DCACHE_BLOCK_SIZE = 64;     // words per data-cache block
  localparam int DCACHE_SIZE       = 16384;  // words in the data cache

  localparam int BURST_LEN_DEF = DCACHE_BLOCK_SIZE;
  localparam int OFS_W_DEF     = $clog2(BURST_LEN_DEF);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    RD        = 3'd1,
    WR_SETUP  = 3'd2,
    WR_STROBE = 3'd3,
    DONE      = 3'd4
  } burst_state_e;

endpackage

// File: rtl/dmem_burst_addr_gen.sv
// Block base register, wrapping word-offset counter and registered memory word address.
module dmem_burst_addr_gen #(
  parameter int ADDR_W = 32,
  parameter int OFS_W  = 6
) (
  input  logic              clk,
  input  logic              srst,
  input  logic              load,
  input  logic              advance,
  input  logic              clear,
  input  logic [ADDR_W-1:0] blk_addr,
  input  logic [OFS_W-1:0]  start,
  output logic [OFS_W-1:0]  offset,
  output logic [OFS_W-1:0]  next_offset,
  output logic [ADDR_W-1:0] mem_addr
);

  logic [ADDR_W-OFS_W-1:0] base_reg;
  logic [OFS_W-1:0]        ofs_reg;
  logic [ADDR_W-1:0]       mem_addr_reg;

  // Offset arithmetic is OFS_W wide, so it wraps inside the block on its own.
  assign next_offset = ofs_reg + OFS_W'(1);
  assign offset      = ofs_reg;
  assign mem_addr    = mem_addr_reg;

  always_ff @(posedge clk) begin
    if (srst) begin
      base_reg     <= '0;
      ofs_reg      <= '0;
      mem_addr_reg <= '0;
    end else if (load) begin
      base_reg     <= blk_addr[ADDR_W-1:OFS_W];
      ofs_reg      <= start;
      mem_addr_reg <= {blk_addr[ADDR_W-1:OFS_W], start};
    end else if (advance) begin
      ofs_reg      <= next_offset;
      mem_addr_reg <= {base_reg, next_offset};
    end else if (clear) begin
      ofs_reg      <= '0;
    end
  end

endmodule

// File: rtl/dmem_burst_master.sv
// Data-memory burst master: moves one cache block between the line buffer and memory.
// Optional DMEM_CRITICAL_WORD_FIRST_EN: refills start at the requested word and wrap.
module dmem_burst_master
  import dmem_burst_master_pkg::*;
#(
  parameter  int ADDR_W    = 32,
  parameter  int DATA_W    = 32,
  parameter  int BURST_LEN = BURST_LEN_DEF,
  localparam int OFS_W     = $clog2(BURST_LEN)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              done,
  output logic [OFS_W-1:0]  buf_addr,
  input  logic [DATA_W-1:0] buf_wdata,
  output logic              buf_we,
  output logic [DATA_W-1:0] buf_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  inout  wire  [DATA_W-1:0] mem_data,
  output logic              mem_read,
  output logic              mem_write
);

  burst_state_e      state_reg;
  logic [OFS_W-1:0]  cnt_reg;
  logic [DATA_W-1:0] wdata_reg;
  logic              mem_read_reg;
  logic              mem_write_reg;
  logic              drive_reg;
  logic              done_reg;
  logic              req_ready_reg;

  logic              accept;
  logic              last;
  logic              advance;
  logic              clear;
  logic [OFS_W-1:0]  start_ofs;
  logic [OFS_W-1:0]  offset;
  logic [OFS_W-1:0]  next_offset;

  assign accept  = req_valid && req_ready_reg;
  assign last    = &cnt_reg;
  // mem_addr stops on the final word rather than wrapping back to the block start.
  assign advance = ((state_reg == RD) || (state_reg == WR_STROBE)) && !last;
  assign clear   = (state_reg == DONE);

`ifdef DMEM_CRITICAL_WORD_FIRST_EN
  assign start_ofs = req_write ? '0 : req_addr[OFS_W-1:0];
`else
  assign start_ofs = '0;
`endif

  dmem_burst_addr_gen #(
    .ADDR_W (ADDR_W),
    .OFS_W  (OFS_W)
  ) u_addr_gen (
    .clk         (clk),
    .srst        (rst),
    .load        (accept),
    .advance     (advance),
    .clear       (clear),
    .blk_addr    (req_addr),
    .start       (start_ofs),
    .offset      (offset),
    .next_offset (next_offset),
    .mem_addr    (mem_addr)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      wdata_reg     <= '0;
      mem_read_reg  <= 1'b0;
      mem_write_reg <= 1'b0;
      drive_reg     <= 1'b0;
      done_reg      <= 1'b0;
      req_ready_reg <= 1'b1;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (accept) begin
            cnt_reg       <= '0;
            req_ready_reg <= 1'b0;
            if (req_write) begin
              state_reg <= WR_SETUP;
              wdata_reg <= buf_wdata;
              drive_reg <= 1'b1;
            end else begin
              state_reg    <= RD;
              mem_read_reg <= 1'b1;
            end
          end
        end
        RD: begin
          if (last) begin
            state_reg    <= DONE;
            mem_read_reg <= 1'b0;
            done_reg     <= 1'b1;
          end else begin
            cnt_reg <= cnt_reg + OFS_W'(1);
          end
        end
        WR_SETUP: begin
          state_reg     <= WR_STROBE;
          mem_write_reg <= 1'b1;
        end
        WR_STROBE: begin
          mem_write_reg <= 1'b0;
          if (last) begin
            state_reg <= DONE;
            drive_reg <= 1'b0;
            done_reg  <= 1'b1;
          end else begin
            // buf_addr already points at the next word, so its data is ready here.
            state_reg <= WR_SETUP;
            cnt_reg   <= cnt_reg + OFS_W'(1);
            wdata_reg <= buf_wdata;
          end
        end
        DONE: begin
          state_reg     <= IDLE;
          req_ready_reg <= 1'b1;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign req_ready = req_ready_reg;
  assign done      = done_reg;
  assign mem_read  = mem_read_reg;
  assign mem_write = mem_write_reg;
  assign buf_we    = (state_reg == RD);
  assign buf_addr  = (state_reg == WR_STROBE) ? next_offset : offset;
  assign buf_rdata = mem_data;
  assign mem_data  = drive_reg ? wdata_reg : {DATA_W{1'bz}};

endmodule
